rob_mc: RTL

- Parametrised reorder buffer for the out-of-order RV32I core, successor to the single-commit ROB.
- Sits between decoder/issue (allocation), RS/LSB (result broadcast over NCDB channels), register file (rename lookup, commit writes) and fetch (mispredict flush).
- New relative to the single-commit ROB:
  - up to CW in-order commits per cycle;
  - N broadcast channels;
  - counter-based full/empty;
  - registered one-cycle flush pulse.

---
 rtl/rob_pkg.sv | 28 ++
 rtl/rob_fwd.sv | 56 +++++
 rtl/rob_mc.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Reorder buffer shared definitions.
// Provides the instruction-kind encoding, default geometry (tag width,
// broadcast channel count, commit width) and the payload field widths
// used by rob_mc and rob_fwd.
package rob_pkg;

  localparam int unsigned TAG_W_DEF = 4;
  localparam int unsigned NCDB_DEF  = 2;
  localparam int unsigned CW_DEF    = 2;

  localparam int unsigned KIND_W = 3;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned RD_W   = 5;

  typedef enum logic [KIND_W-1:0] {
    KIND_ALU    = 3'd0,
    KIND_LOAD   = 3'd1,
    KIND_STORE  = 3'd2,
    KIND_BRANCH = 3'd3,
    KIND_IMM    = 3'd4   // LUI/AUIPC/JAL/JALR, value known at issue
  } kind_e;

  // Stores and branches never write the register file.
  function automatic logic kind_writes_rd(input kind_e k);
    return (k != KIND_STORE) && (k != KIND_BRANCH);
  endfunction

endpackage

// File: rtl/rob_fwd.sv
// Single operand lookup into the reorder buffer.
// Ports:
//   qry_tag              entry being looked up
//   ent_done/ent_value   stored state of that entry
//   cdb_valid/tag/value  broadcast channels this cycle
//   imm_hit/imm_value    same-cycle IMM issue into the queried entry
//   qry_ready/qry_value  lookup result (value 0 when not ready)
// Priority: stored value, then lowest matching channel, then IMM issue.
module rob_fwd
  import rob_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF,
  parameter int unsigned NCDB  = NCDB_DEF
) (
  input  logic [TAG_W-1:0]      qry_tag,
  input  logic                  ent_done,
  input  logic [XLEN-1:0]       ent_value,
  input  logic [NCDB-1:0]       cdb_valid,
  input  logic [NCDB*TAG_W-1:0] cdb_tag,
  input  logic [NCDB*XLEN-1:0]  cdb_value,
  input  logic                  imm_hit,
  input  logic [XLEN-1:0]       imm_value,
  output logic                  qry_ready,
  output logic [XLEN-1:0]       qry_value
);

  logic            cdb_hit;
  logic [XLEN-1:0] cdb_val;

  always_comb begin
    cdb_hit = 1'b0;
    cdb_val = '0;
    for (int unsigned i = 0; i < NCDB; i++) begin
      if (!cdb_hit && cdb_valid[i] && (cdb_tag[i*TAG_W +: TAG_W] == qry_tag)) begin
        cdb_hit = 1'b1;
        cdb_val = cdb_value[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    qry_ready = 1'b0;
    qry_value = '0;
    if (ent_done) begin
      qry_ready = 1'b1;
      qry_value = ent_value;
    end else if (cdb_hit) begin
      qry_ready = 1'b1;
      qry_value = cdb_val;
    end else if (imm_hit) begin
      qry_ready = 1'b1;
      qry_value = imm_value;
    end
  end

endmodule

// File: rtl/rob_mc.sv
// Multi-commit reorder buffer for the out-of-order RV32I core.
// Ports:
//   clk_in, rst_n_in (async active-low), rdy_in (global stall when low)
//   issue_*   : one allocation per cycle at the tail; issue_tag = tail
//   cdb_*     : NCDB result broadcast channels
//   qry_*     : two combinational operand lookups with forwarding
//   commit_*  : up to CW in-order retirements per cycle
//   flush/flush_pc : registered one-cycle mispredict redirect
//   count     : occupied entries (full at DEPTH, no sacrificed slot)
module rob_mc
  import rob_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF,
  parameter int unsigned NCDB  = NCDB_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  output logic [TAG_W-1:0]      issue_tag,
  input  logic [KIND_W-1:0]     issue_kind,
  input  logic [XLEN-1:0]       issue_pc,
  input  logic [RD_W-1:0]       issue_rd,
  input  logic [XLEN-1:0]       issue_value,
  input  logic                  issue_pred,
  input  logic [XLEN-1:0]       issue_target,
  input  logic [NCDB-1:0]       cdb_valid,
  input  logic [NCDB*TAG_W-1:0] cdb_tag,
  input  logic [NCDB*XLEN-1:0]  cdb_value,
  input  logic [TAG_W-1:0]      qry_tag1,
  input  logic [TAG_W-1:0]      qry_tag2,
  output logic                  qry_ready1,
  output logic                  qry_ready2,
  output logic [XLEN-1:0]       qry_value1,
  output logic [XLEN-1:0]       qry_value2,
  output logic [CW-1:0]         commit_valid,
  output logic [CW-1:0]         commit_wr,
  output logic [CW*RD_W-1:0]    commit_rd,
  output logic [CW*TAG_W-1:0]   commit_tag,
  output logic [CW*XLEN-1:0]    commit_value,
  output logic                  flush,
  output logic [XLEN-1:0]       flush_pc,
  output logic [TAG_W:0]        count
);

  localparam int unsigned   DEPTH     = 1 << TAG_W;
  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

  // Control state
  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   cnt;
  logic [DEPTH-1:0] busy, done;
  logic             flush_q;
  logic [XLEN-1:0]  flush_pc_q;

  // Payload (no reset: only read while busy/done qualify it)
  kind_e            kind_q   [DEPTH];
  logic [XLEN-1:0]  pc_q     [DEPTH];
  logic [XLEN-1:0]  value_q  [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];
  logic [RD_W-1:0]  rd_q     [DEPTH];
  logic [DEPTH-1:0] pred_q;

  logic             issue_fire;
  logic             issue_is_imm;
  logic [TAG_W:0]   n_commit;
  logic             mispredict;
  logic             mp_taken;
  logic [XLEN-1:0]  mp_pc, mp_target;
  logic [DEPTH-1:0] busy_nxt, done_nxt;

  assign issue_ready  = (cnt != DEPTH_CNT);
  assign issue_tag    = tail;
  assign count        = cnt;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;
  assign issue_is_imm = (issue_kind == KIND_IMM);
  assign issue_fire   = rdy_in && issue_valid && issue_ready;

  // Commit selection: a contiguous run of done entries from head, cut
  // short after the first mispredicted branch.
  always_comb begin
    logic             chain;
    logic [TAG_W-1:0] idx;
    commit_valid = '0;
    commit_wr    = '0;
    commit_rd    = '0;
    commit_tag   = '0;
    commit_value = '0;
    n_commit     = '0;
    mispredict   = 1'b0;
    mp_taken     = 1'b0;
    mp_pc        = '0;
    mp_target    = '0;
    chain        = rdy_in;
    idx          = '0;
    for (int unsigned k = 0; k < CW; k++) begin
      idx = head + TAG_W'(k);
      if (chain && (cnt > (TAG_W+1)'(k)) && busy[idx] && done[idx]) begin
        commit_valid[k]                 = 1'b1;
        commit_wr[k]                    = kind_writes_rd(kind_q[idx]) && (rd_q[idx] != '0);
        commit_rd[k*RD_W +: RD_W]       = rd_q[idx];
        commit_tag[k*TAG_W +: TAG_W]    = idx;
        commit_value[k*XLEN +: XLEN]    = value_q[idx];
        n_commit                        = n_commit + (TAG_W+1)'(1);
        if ((kind_q[idx] == KIND_BRANCH) && (value_q[idx][0] != pred_q[idx])) begin
          mispredict = 1'b1;
          mp_taken   = value_q[idx][0];
          mp_pc      = pc_q[idx];
          mp_target  = target_q[idx];
          chain      = 1'b0;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

  // Next busy/done: retire, then allocate, then accept broadcasts that
  // target live, not-yet-done entries (old state, so the tail being
  // allocated this cycle can never be hit).
  always_comb begin
    logic [TAG_W-1:0] idx;
    logic [TAG_W-1:0] t;
    busy_nxt = busy;
    done_nxt = done;
    idx      = '0;
    t        = '0;
    for (int unsigned k = 0; k < CW; k++) begin
      idx = head + TAG_W'(k);
      if (commit_valid[k]) begin
        busy_nxt[idx] = 1'b0;
        done_nxt[idx] = 1'b0;
      end
    end
    if (issue_fire) begin
      busy_nxt[tail] = 1'b1;
      done_nxt[tail] = issue_is_imm;
    end
    for (int unsigned i = 0; i < NCDB; i++) begin
      t = cdb_tag[i*TAG_W +: TAG_W];
      if (cdb_valid[i] && busy[t] && !done[t]) begin
        done_nxt[t] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      busy       <= '0;
      done       <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else if (rdy_in) begin
      if (mispredict) begin
        head       <= '0;
        tail       <= '0;
        cnt        <= '0;
        busy       <= '0;
        done       <= '0;
        flush_q    <= 1'b1;
        flush_pc_q <= mp_taken ? mp_target : (mp_pc + 32'd4);
      end else begin
        head    <= head + n_commit[TAG_W-1:0];
        tail    <= tail + TAG_W'(issue_fire);
        cnt     <= cnt + (TAG_W+1)'(issue_fire) - n_commit;
        busy    <= busy_nxt;
        done    <= done_nxt;
        flush_q <= 1'b0;
      end
    end
  end

  // Payload writes. Channels are walked from the highest index down so the
  // lowest-index channel's write lands last and wins on a duplicate tag.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !mispredict) begin
      if (issue_fire) begin
        kind_q[tail]   <= kind_e'(issue_kind);
        pc_q[tail]     <= issue_pc;
        rd_q[tail]     <= issue_rd;
        pred_q[tail]   <= issue_pred;
        target_q[tail] <= issue_target;
        value_q[tail]  <= issue_is_imm ? issue_value : '0;
      end
      for (int unsigned j = 0; j < NCDB; j++) begin
        if (cdb_valid[NCDB-1-j] && busy[cdb_tag[(NCDB-1-j)*TAG_W +: TAG_W]]
            && !done[cdb_tag[(NCDB-1-j)*TAG_W +: TAG_W]]) begin
          value_q[cdb_tag[(NCDB-1-j)*TAG_W +: TAG_W]] <= cdb_value[(NCDB-1-j)*XLEN +: XLEN];
        end
      end
    end
  end

  // A broadcast must target an allocated entry that has not completed.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && rdy_in) begin
      for (int unsigned i = 0; i < NCDB; i++) begin
        if (cdb_valid[i]) begin
          assert (busy[cdb_tag[i*TAG_W +: TAG_W]] && !done[cdb_tag[i*TAG_W +: TAG_W]]);
        end
      end
    end
  end

  rob_fwd #(.TAG_W(TAG_W), .NCDB(NCDB)) u_fwd1 (
    .qry_tag   (qry_tag1),
    .ent_done  (done[qry_tag1]),
    .ent_value (value_q[qry_tag1]),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .imm_hit   (issue_valid && issue_is_imm && (qry_tag1 == tail)),
    .imm_value (issue_value),
    .qry_ready (qry_ready1),
    .qry_value (qry_value1)
  );

  rob_fwd #(.TAG_W(TAG_W), .NCDB(NCDB)) u_fwd2 (
    .qry_tag   (qry_tag2),
    .ent_done  (done[qry_tag2]),
    .ent_value (value_q[qry_tag2]),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .imm_hit   (issue_valid && issue_is_imm && (qry_tag2 == tail)),
    .imm_value (issue_value),
    .qry_ready (qry_ready2),
    .qry_value (qry_value2)
  );

endmodule
